// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI mode-0 master shift engine, MSB first
//
// Purpose: drives MOSI, samples MISO and controls chip-select from the
// single-cycle SCLK rise/fall pulses of the upstream edge detector, and
// requests SCLK toggling from the clock generator through sclk_en.
//
// Ports:
//   clk, reset     system clock; synchronous active-high reset
//   start          transfer request, sampled only in IDLE
//   tx_data        word to send, captured on an accepted start
//   sclk_rise      one-cycle pulse on each SCLK rising edge
//   sclk_fall      one-cycle pulse on each SCLK falling edge
//   miso           serial data from the slave
//   sclk_en        SCLK toggle request to the clock generator
//   mosi           serial data to the slave
//   cs_n           active-low chip select
//   busy           high whenever the engine is not idle
//   done           one-cycle pulse when rx_data is updated
//   rx_data        last received word, held until the next done

module spi_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CS_SETUP   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  sclk_rise,
    input  logic                  sclk_fall,
    input  logic                  miso,
    output logic                  sclk_en,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int SW = $clog2(CS_SETUP + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH);
    localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        FINISH
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BW-1:0]         bit_cnt;
    logic [SW-1:0]         setup_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            setup_cnt <= '0;
            sclk_en   <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            done      <= 1'b0;
            rx_data   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift  <= tx_data;
                        mosi      <= tx_data[DATA_WIDTH-1];
                        cs_n      <= 1'b0;
                        bit_cnt   <= '0;
                        setup_cnt <= '0;
                        state     <= SETUP;
                    end
                end

                // Edge pulses are ignored while chip-select setup time elapses.
                SETUP: begin
                    setup_cnt <= setup_cnt + SW'(1);
                    if (setup_cnt == SETUP_LAST) begin
                        sclk_en <= 1'b1;
                        state   <= XFER;
                    end
                end

                // A rise always wins over a coincident fall. A fall before the
                // first rise is illegal for CPOL=0 and is dropped; a fall after
                // the last rise ends the transfer with mosi held.
                XFER: begin
                    if (sclk_rise) begin
                        if (bit_cnt != BIT_LAST) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
                            bit_cnt  <= bit_cnt + BW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == BIT_LAST) begin
                            sclk_en <= 1'b0;
                            state   <= FINISH;
                        end else if (bit_cnt != '0) begin
                            tx_shift <= tx_shift << 1;
                            mosi     <= tx_shift[DATA_WIDTH-2];
                        end
                    end
                end

                FINISH: begin
                    cs_n    <= 1'b1;
                    rx_data <= rx_shift;
                    done    <= 1'b1;
                    mosi    <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - self-checking bench for spi_shift_engine
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [15:0] tx_data;
    logic        sclk_rise, sclk_fall, miso;

    logic        sclk_en_a, mosi_a, cs_n_a, busy_a, done_a;
    logic [7:0]  rx_a;
    logic        sclk_en_b, mosi_b, cs_n_b, busy_b, done_b;
    logic [15:0] rx_b;

    int          sel;
    logic        o_sclk_en, o_mosi, o_cs_n, o_busy, o_done;
    logic [15:0] o_rx;

    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    spi_shift_engine #(.DATA_WIDTH(8), .CS_SETUP(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tx_data(tx_data[7:0]),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .miso(miso),
        .sclk_en(sclk_en_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a),
        .done(done_a), .rx_data(rx_a)
    );

    spi_shift_engine #(.DATA_WIDTH(16), .CS_SETUP(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_data),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .miso(miso),
        .sclk_en(sclk_en_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b),
        .done(done_b), .rx_data(rx_b)
    );

    always_comb begin
        o_sclk_en = sclk_en_a;
        o_mosi    = mosi_a;
        o_cs_n    = cs_n_a;
        o_busy    = busy_a;
        o_done    = done_a;
        o_rx      = {8'h00, rx_a};
        if (sel != 0) begin
            o_sclk_en = sclk_en_b;
            o_mosi    = mosi_b;
            o_cs_n    = cs_n_b;
            o_busy    = busy_b;
            o_done    = done_b;
            o_rx      = rx_b;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("no_early_done", {15'd0, o_done}, 16'd0);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s != 0) start_b = v;
        else        start_a = v;
    endtask

    // Reference: bit k of the transfer is tx[w-1-k] on MOSI and pat[w-1-k]
    // on MISO; received word equals the MISO pattern; timing from the
    // documented edge relationships.
    task automatic xfer(input int s, input logic [15:0] tx, input logic [15:0] pat,
                        input int gap, input bit hold, input bit mid_start,
                        input bit illegal, input int abort_after);
        int w, cs, n, g;
        w  = (s != 0) ? 16 : 8;
        cs = (s != 0) ? 1 : 2;
        sel = s;
        tx_data = tx;
        set_start(s, 1'b1);
        step();
        check("e0_cs_n", {15'd0, o_cs_n}, 16'd0);
        check("e0_busy", {15'd0, o_busy}, 16'd1);
        check("e0_mosi", {15'd0, o_mosi}, {15'd0, tx[w-1]});
        check("e0_sclk_en", {15'd0, o_sclk_en}, 16'd0);
        check("e0_done", {15'd0, o_done}, 16'd0);
        if (!hold) set_start(s, 1'b0);
        n = 0;
        while (!o_sclk_en && n < 20) begin
            step();
            n++;
        end
        check("setup_len", 16'(n), 16'(cs));
        for (int k = 0; k < w; k++) begin
            g = (gap == 0) ? int'($urandom_range(1, 4)) : gap;
            if (mid_start && k == 3) begin
                set_start(s, 1'b1);
                tx_data = 16'h0012;
                step();
                set_start(s, 1'b0);
            end
            if (illegal && k == 0) begin
                sclk_fall = 1'b1;
                step();
                sclk_fall = 1'b0;
                check("early_fall_no_shift", {15'd0, o_mosi}, {15'd0, tx[w-1]});
            end
            idle(g);
            check("mosi_pre_rise", {15'd0, o_mosi}, {15'd0, tx[w-1-k]});
            miso = pat[w-1-k];
            sclk_rise = 1'b1;
            if (illegal && k == 2) sclk_fall = 1'b1;
            step();
            sclk_rise = 1'b0;
            sclk_fall = 1'b0;
            miso = 1'($urandom_range(0, 1));
            check("mosi_post_rise", {15'd0, o_mosi}, {15'd0, tx[w-1-k]});
            if (abort_after > 0 && k + 1 == abort_after) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check("rst_cs_n", {15'd0, o_cs_n}, 16'd1);
                check("rst_sclk_en", {15'd0, o_sclk_en}, 16'd0);
                check("rst_mosi", {15'd0, o_mosi}, 16'd0);
                check("rst_rx", o_rx, 16'd0);
                check("rst_busy", {15'd0, o_busy}, 16'd0);
                check("rst_done", {15'd0, o_done}, 16'd0);
                return;
            end
            idle(g);
            sclk_fall = 1'b1;
            step();
            sclk_fall = 1'b0;
            if (k < w - 1) begin
                check("mosi_post_fall", {15'd0, o_mosi}, {15'd0, tx[w-2-k]});
                check("mid_sclk_en", {15'd0, o_sclk_en}, 16'd1);
                check("mid_cs_n", {15'd0, o_cs_n}, 16'd0);
            end else begin
                check("ef_sclk_en", {15'd0, o_sclk_en}, 16'd0);
                check("ef_cs_n", {15'd0, o_cs_n}, 16'd0);
                check("ef_busy", {15'd0, o_busy}, 16'd1);
                check("ef_done", {15'd0, o_done}, 16'd0);
                check("ef_mosi_held", {15'd0, o_mosi}, {15'd0, tx[0]});
            end
        end
        step();
        check("ef1_cs_n", {15'd0, o_cs_n}, 16'd1);
        check("ef1_done", {15'd0, o_done}, 16'd1);
        check("ef1_rx", o_rx, pat);
        check("ef1_busy", {15'd0, o_busy}, 16'd0);
        check("ef1_mosi", {15'd0, o_mosi}, 16'd0);
    endtask

    typedef struct {
        int          s;
        logic [15:0] tx;
        logic [15:0] pat;
        logic [15:0] exp_rx;
        int          gap;
        bit          hold;
        bit          mid;
        bit          ill;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [15:0] tx, pat, mask;
        int s;
        tbl[0] = '{0, 16'h00A5, 16'h003C, 16'h003C, 3, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{0, 16'h00FF, 16'h0081, 16'h0081, 2, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{0, 16'h0000, 16'h007E, 16'h007E, 1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{0, 16'h00C3, 16'h0096, 16'h0096, 0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{0, 16'h006B, 16'h00D2, 16'h00D2, 0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1, 16'hBEEF, 16'h1234, 16'h1234, 2, 1'b0, 1'b0, 1'b0};

        sel = 0;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tx_data = '0;
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        miso = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #0;
            check("reset_cs_n", {15'd0, o_cs_n}, 16'd1);
            check("reset_sclk_en", {15'd0, o_sclk_en}, 16'd0);
            check("reset_mosi", {15'd0, o_mosi}, 16'd0);
            check("reset_busy", {15'd0, o_busy}, 16'd0);
            check("reset_done", {15'd0, o_done}, 16'd0);
            check("reset_rx", o_rx, 16'd0);
        end

        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].s, tbl[i].tx, tbl[i].exp_rx, tbl[i].gap, tbl[i].hold,
                 tbl[i].mid, tbl[i].ill, 0);
            check("table_rx", o_rx, tbl[i].exp_rx);
            if (!tbl[i].hold) begin
                step();
                check("done_one_cycle", {15'd0, o_done}, 16'd0);
                check("rx_held", o_rx, tbl[i].exp_rx);
            end
            if (tbl[i].mid) begin
                for (int j = 0; j < 5; j++) begin
                    step();
                    check("no_second_xfer", {14'd0, o_busy, o_done}, 16'd0);
                end
            end
        end

        // Reset after three rises, then a clean transfer
        xfer(0, 16'h00A7, 16'h0055, 1, 1'b0, 1'b0, 1'b0, 3);
        for (int j = 0; j < 4; j++) begin
            step();
            check("no_done_after_reset", {15'd0, o_done}, 16'd0);
        end
        xfer(0, 16'h005A, 16'h00C9, 0, 1'b0, 1'b0, 1'b0, 0);
        step();

        // Randomized transfers on both widths
        for (int i = 0; i < 20; i++) begin
            s    = int'($urandom_range(0, 1));
            mask = (s != 0) ? 16'hFFFF : 16'h00FF;
            tx   = 16'($urandom) & mask;
            pat  = 16'($urandom) & mask;
            xfer(s, tx, pat, 0, 1'b0, 1'b0, (i % 5) == 4, 0);
            step();
            check("rand_done_low", {15'd0, o_done}, 16'd0);
            check("rand_rx_held", o_rx, pat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

SPI mode-0 (CPOL=0, CPHA=0) master shift engine, MSB first. It consumes the single-cycle SCLK rise and fall pulses produced by the SCLK edge-detector stage. On those pulses it drives MOSI, samples MISO, controls chip-select and returns the received word. It sits directly downstream of the edge detector and requests SCLK toggling from the clock generator through `sclk_en`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per transfer; must be ≥ 2.
- `CS_SETUP`, default 2: clk cycles `cs_n` is low before `sclk_en` rises; must be ≥ 1.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: transfer request; sampled only in IDLE.
- `tx_data` in DATA_WIDTH: word to send; captured on accepted `start`.
- `sclk_rise` in 1: one-cycle pulse, SCLK rising edge (from edge detector).
- `sclk_fall` in 1: one-cycle pulse, SCLK falling edge (from edge detector).
- `miso` in 1: serial data from slave.
- `sclk_en` out 1: request to clock generator to toggle SCLK (idle low).
- `mosi` out 1: serial data to slave.
- `cs_n` out 1: chip select, active-low.
- `busy` out 1: high whenever state ≠ IDLE (combinational decode of state).
- `done` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_data` out DATA_WIDTH: last received word; held until the next `done`.

## Operation
- Reset values: state IDLE, `cs_n`=1, `sclk_en`=0, `mosi`=0, `done`=0, `busy`=0, `rx_data`=0, internal counters and shift registers 0.
- IDLE:
  - `start`=1 → load tx shift reg with `tx_data`, `mosi`←`tx_data[DATA_WIDTH-1]`, `cs_n`←0, clear `bit_cnt` and `setup_cnt`, go to SETUP.
- SETUP:
  - `setup_cnt` increments each cycle.
  - When `setup_cnt`==CS_SETUP-1: `sclk_en`←1, go to XFER.
  - Edge pulses are ignored.
- XFER:
  - `sclk_rise`: rx shift ← {rx shift[DATA_WIDTH-2:0], `miso`}; `bit_cnt`++.
  - `sclk_fall` with `bit_cnt`==0: ignored (SCLK idles low, so a fall cannot legally come first).
  - `sclk_fall` with 0<`bit_cnt`<DATA_WIDTH: tx shift reg shifts left by 1; `mosi` ← new MSB.
  - `sclk_fall` with `bit_cnt`==DATA_WIDTH: `sclk_en`←0, go to FINISH. `mosi` is held.
  - `sclk_rise` and `sclk_fall` in the same cycle: the rise is processed and the fall is dropped.
  - Rise pulses beyond DATA_WIDTH do not occur, because `sclk_en` drops; if one arrives anyway it is ignored and `bit_cnt` saturates at DATA_WIDTH.
- FINISH (1 cycle): `cs_n`←1, `rx_data`←rx shift, `done`←1, `mosi`←0, go to IDLE.
- `start` outside IDLE is ignored; `tx_data` is not re-sampled during a transfer.
- `reset` mid-transfer: all outputs return to reset values at the same edge. No `done` is issued and `rx_data` is cleared to 0.
- Widths:
  - `bit_cnt` is clog2(DATA_WIDTH+1) bits.
  - `setup_cnt` is clog2(CS_SETUP+1) bits.

## Timing
- `start` sampled at edge E0 → `cs_n`=0 and `busy`=1 from E0; `mosi` valid with the MSB from E0.
- `sclk_en`=1 from edge E0+CS_SETUP.
- MOSI bit k changes only on the edge that samples a fall pulse. It is stable across the following rise, giving a half-SCLK setup.
- The final (DATA_WIDTH-th) fall pulse is sampled at Ef:
  - `sclk_en`=0 from Ef.
  - At Ef+1: `cs_n`=1, `done`=1, `rx_data` valid, `busy`=0.
  - `done`=0 at Ef+2.
- Earliest next accepted `start` is sampled at Ef+2. Minimum `cs_n` high time is 1 cycle.
- `rx_data` changes only in the same cycle `done` is high.

## Test plan
- Basic transfer, CS_SETUP=2:
  - Stimulus: `tx_data`=0xA5; bench drives alternating rise/fall pulses 4 cycles apart; MISO presents 0x3C MSB first on each rise.
  - Required: `mosi` sequence 1,0,1,0,0,1,0,1 at each rise; `rx_data`=0x3C with `done` pulse exactly 1 cycle; `cs_n` low exactly from E0 to Ef+1; `sclk_en` high from E0+2.
- Back-to-back:
  - Stimulus: `start` held high; words 0xFF then 0x00.
  - Required: second transfer accepted at Ef+2; `cs_n` high exactly 1 cycle between transfers; `rx_data` = MISO patterns 0x81 then 0x7E.
- Start while busy:
  - Stimulus: pulse `start` with `tx_data`=0x12 mid-XFER of 0xC3.
  - Required: MOSI still emits 0xC3; no second transfer; a single `done`.
- Reset mid-transfer:
  - Stimulus: assert `reset` after 3 rise pulses.
  - Required: next cycle `cs_n`=1, `sclk_en`=0, `mosi`=0, `rx_data`=0, `busy`=0; no `done`; a new 0x5A transfer afterwards completes correctly.
- Illegal pulses:
  - Stimulus: a fall before the first rise, plus one cycle with rise and fall asserted together.
  - Required: the early fall causes no MOSI shift; the simultaneous cycle counts as a rise only; the transfer completes after DATA_WIDTH further correct falls with the correct `rx_data`.
- Parameter sweep:
  - Stimulus: DATA_WIDTH=16, CS_SETUP=1, `tx_data`=0xBEEF, MISO pattern 0x1234.
  - Required: `sclk_en` rises at E0+1; `rx_data`=0x1234; MOSI = 0xBEEF MSB first.
